// File: rtl/mult_div_pkg.sv
// mult_div_pkg
// Shared definitions for the iterative HI/LO multiply/divide unit:
//   WIDTH   operand width (only 32 is exercised)
//   ITERS   number of shift-add / shift-subtract steps per operation
//   state_e FSM states IDLE -> ITER -> FIX -> IDLE
//   OP_MULT / OP_DIV   meaning of the multdivb control bit
package mult_div_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic OP_MULT = 1'b1;
    localparam logic OP_DIV  = 1'b0;

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if
// Request/result bundle between the core (master) and the multiply/divide
// unit (slave).
//   start        launch pulse, sampled on rising clk
//   multdivb     1 = multiply, 0 = divide
//   signedop     1 = two's-complement operands
//   x, y         multiplicand/dividend, multiplier/divisor
//   prodh        mul: product high word; div: remainder
//   prodl        mul: product low word;  div: quotient
//   run          unit busy
//   dividebyzero last launched op was a divide by zero
interface mult_div_if;
    import mult_div_pkg::*;

    logic             start;
    logic             multdivb;
    logic             signedop;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] prodh;
    logic [WIDTH-1:0] prodl;
    logic             run;
    logic             dividebyzero;

    modport master (
        output start, multdivb, signedop, x, y,
        input  prodh, prodl, run, dividebyzero
    );

    modport slave (
        input  start, multdivb, signedop, x, y,
        output prodh, prodl, run, dividebyzero
    );

endinterface

// File: rtl/mult_div_negate.sv
// mult_div_negate
// Combinational conditional two's complement, used both to take operand
// magnitudes and to restore result signs.
//   neg_i  1 = output -a_i, 0 = output a_i
//   a_i    W-bit input value
//   y_o    W-bit result
module mult_div_negate #(
    parameter int W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? -a_i : a_i;

endmodule

// File: rtl/mult_div.sv
// mult_div
// Iterative radix-2 32x32 multiplier / restoring divider for the HI/LO unit.
// One start pulse launches one operation; run stays high for 33 cycles and
// results appear on prodh/prodl on the edge where run falls, held until the
// next operation finishes.
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous, active-high
//   bus    mult_div_if.slave (start/multdivb/signedop/x/y in,
//          prodh/prodl/run/dividebyzero out)
// Configuration macro:
//   MULT_DIV_DBZ_SHORTCUT_EN  when defined, a divide by zero skips the
//                             iteration and completes after one cycle.
module mult_div
    import mult_div_pkg::*;
(
    input logic       clk,
    input logic       reset,
    mult_div_if.slave bus
);

    localparam int W2 = 2 * WIDTH;

    state_e           state_q;
    logic [4:0]       stepCnt_q;
    logic             isMult_q;
    logic             negLo_q;
    logic             negHi_q;
    logic [W2-1:0]    acc_q;
    logic [W2-1:0]    acc_d;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] prodh_q;
    logic [WIDTH-1:0] prodl_q;
    logic             run_q;
    logic             dbz_q;

    logic             signX;
    logic             signY;
    logic             isDbz;
    logic [WIDTH-1:0] xAbs;
    logic [WIDTH-1:0] yAbs;
    logic [W2-1:0]    prodFix;
    logic [WIDTH-1:0] remFix;
    logic [WIDTH-1:0] quoFix;

    assign signX = bus.signedop & bus.x[WIDTH-1];
    assign signY = bus.signedop & bus.y[WIDTH-1];
    assign isDbz = (bus.multdivb == OP_DIV) && (bus.y == '0);

    // A divide by zero keeps x unmodified so that the restoring divider
    // naturally produces quotient all-ones and remainder x.
    mult_div_negate #(.W(WIDTH)) uAbsX (
        .neg_i (signX & ~isDbz),
        .a_i   (bus.x),
        .y_o   (xAbs)
    );

    mult_div_negate #(.W(WIDTH)) uAbsY (
        .neg_i (signY),
        .a_i   (bus.y),
        .y_o   (yAbs)
    );

    mult_div_negate #(.W(W2)) uFixProd (
        .neg_i (negLo_q),
        .a_i   (acc_q),
        .y_o   (prodFix)
    );

    mult_div_negate #(.W(WIDTH)) uFixRem (
        .neg_i (negHi_q),
        .a_i   (acc_q[W2-1:WIDTH]),
        .y_o   (remFix)
    );

    mult_div_negate #(.W(WIDTH)) uFixQuo (
        .neg_i (negLo_q),
        .a_i   (acc_q[WIDTH-1:0]),
        .y_o   (quoFix)
    );

    // One iteration step on the {high, low} accumulator.
    // Multiply: low half holds the remaining multiplier bits; add the
    // multiplicand into the high half when the current bit is set, then
    // shift the 65-bit result right.
    // Divide: {remainder, dividend} shifts left; the remainder is replaced
    // by the trial difference whenever the divisor fits, and the quotient
    // bit shifts in at the bottom.
    logic [WIDTH:0]   mulSum;
    logic             divFits;
    logic [WIDTH-1:0] divRem;

    always_comb begin
        mulSum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opB_q} : '0);
        divFits = acc_q[W2-1:WIDTH-1] >= {1'b0, opB_q};
        divRem  = acc_q[W2-2:WIDTH-1] - opB_q;
        if (isMult_q) begin
            acc_d = {mulSum, acc_q[WIDTH-1:1]};
        end else if (divFits) begin
            acc_d = {divRem, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {acc_q[W2-2:0], 1'b0};
        end
    end

    // Control FSM and all architectural state. Results are only written in
    // FIX so prodh/prodl stay stable for the whole next operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            stepCnt_q <= '0;
            isMult_q  <= 1'b0;
            negLo_q   <= 1'b0;
            negHi_q   <= 1'b0;
            acc_q     <= '0;
            opB_q     <= '0;
            prodh_q   <= '0;
            prodl_q   <= '0;
            run_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        isMult_q  <= (bus.multdivb == OP_MULT);
                        opB_q     <= yAbs;
                        stepCnt_q <= '0;
                        run_q     <= 1'b1;
                        dbz_q     <= isDbz;
                        negLo_q   <= ~isDbz & (signX ^ signY);
                        negHi_q   <= ~isDbz & signX;
`ifdef MULT_DIV_DBZ_SHORTCUT_EN
                        if (isDbz) begin
                            acc_q   <= {bus.x, {WIDTH{1'b1}}};
                            state_q <= FIX;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, xAbs};
                            state_q <= ITER;
                        end
`else
                        acc_q   <= {{WIDTH{1'b0}}, xAbs};
                        state_q <= ITER;
`endif
                    end
                end
                ITER: begin
                    acc_q     <= acc_d;
                    stepCnt_q <= stepCnt_q + 5'd1;
                    if (stepCnt_q == 5'(ITERS - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (isMult_q) begin
                        prodh_q <= prodFix[W2-1:WIDTH];
                        prodl_q <= prodFix[WIDTH-1:0];
                    end else begin
                        prodh_q <= remFix;
                        prodl_q <= quoFix;
                    end
                    run_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.prodh        = prodh_q;
    assign bus.prodl        = prodl_q;
    assign bus.run          = run_q;
    assign bus.dividebyzero = dbz_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div
// Self-checking bench for mult_div: a constant vector table, hand-written
// sequences for the ignored-start and mid-operation reset cases, a corner
// operand sweep and random operations, all against an arithmetic model.
module tb_mult_div;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mult_div_if bus();

    mult_div u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MULT_DIV_DBZ_SHORTCUT_EN
    localparam int DBZ_CYCLES = 1;
`else
    localparam int DBZ_CYCLES = 33;
`endif

    typedef struct {
        logic        mul;
        logic        sgn;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] expH;
        logic [31:0] expL;
        logic        expDbz;
    } vec_t;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        dbz;
    } res_t;

    // Reference model: plain 64-bit arithmetic, SV division truncates toward
    // zero and the remainder follows the dividend, matching the HI/LO rules.
    function automatic res_t model(input logic mul, input logic sgn,
                                   input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        longint      sx;
        longint      sy;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dbz = 1'b0;
        if (mul) begin
            if (sgn) p = 64'(sx * sy);
            else     p = {32'b0, x} * {32'b0, y};
            r.h = p[63:32];
            r.l = p[31:0];
        end else if (y == 32'd0) begin
            r.h   = x;
            r.l   = 32'hFFFFFFFF;
            r.dbz = 1'b1;
        end else if (sgn) begin
            sq  = sx / sy;
            sr  = sx % sy;
            r.h = 32'(sr);
            r.l = 32'(sq);
        end else begin
            r.h = x % y;
            r.l = x / y;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is positioned on a falling edge; start is high for one rising edge.
    task automatic launch(input logic mul, input logic sgn,
                          input logic [31:0] x, input logic [31:0] y);
        bus.start    = 1'b1;
        bus.multdivb = mul;
        bus.signedop = sgn;
        bus.x        = x;
        bus.y        = y;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.run === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic mul, input logic sgn,
                                 input logic [31:0] x, input logic [31:0] y,
                                 input res_t exp);
        int cycles;
        int expCycles;
        launch(mul, sgn, x, y);
        waitDone(cycles);
        expCycles = (exp.dbz && !mul) ? DBZ_CYCLES : 33;
        checkOutput({tag, " prodh"}, bus.prodh, exp.h);
        checkOutput({tag, " prodl"}, bus.prodl, exp.l);
        checkOutput({tag, " dividebyzero"}, {31'b0, bus.dividebyzero}, {31'b0, exp.dbz});
        checkOutput({tag, " runCycles"}, 32'(cycles), 32'(expCycles));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] corners[9];
        res_t        e;
        res_t        eA;
        int          cnt;
        logic        m;
        logic        s;
        logic [31:0] rx;
        logic [31:0] ry;

        vecs[0]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h80000005, 32'h00000000, 32'h80000005, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h00000000, 32'hABCDEF01, 32'h00000000, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};

        corners = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h7FFFFFFF, 32'h80000000,
                    32'hFFFFFFFE, 32'hFFFFFFFF, 32'hABCDEF01, 32'h23456789};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.multdivb = 1'b0;
        bus.signedop = 1'b0;
        bus.x        = '0;
        bus.y        = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset run", {31'b0, bus.run}, 32'd0);
        checkOutput("reset prodh", bus.prodh, 32'd0);
        checkOutput("reset prodl", bus.prodl, 32'd0);
        checkOutput("reset dividebyzero", {31'b0, bus.dividebyzero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, launched back-to-back on the cycle after run falls.
        for (int i = 0; i < 12; i++) begin
            e.h   = vecs[i].expH;
            e.l   = vecs[i].expL;
            e.dbz = vecs[i].expDbz;
            applyStimulus($sformatf("vec%0d", i), vecs[i].mul, vecs[i].sgn,
                          vecs[i].x, vecs[i].y, e);
        end

        // A second start at cycle 10 of a running op must be ignored and the
        // previous result (3*5 = 15 from the last vector) must stay held.
        eA = model(1'b1, 1'b0, 32'd12345, 32'd6789);
        launch(1'b1, 1'b0, 32'd12345, 32'd6789);
        cnt = 0;
        while (bus.run === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 10) begin
                checkOutput("held prodh", bus.prodh, 32'h00000000);
                checkOutput("held prodl", bus.prodl, 32'h0000000F);
                bus.start    = 1'b1;
                bus.multdivb = 1'b0;
                bus.x        = 32'd100;
                bus.y        = 32'd0;
            end
            if (cnt == 11) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput("ignore runCycles", 32'(cnt), 32'd33);
        checkOutput("ignore prodh", bus.prodh, eA.h);
        checkOutput("ignore prodl", bus.prodl, eA.l);
        checkOutput("ignore dividebyzero", {31'b0, bus.dividebyzero}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("ignore no queued op", {31'b0, bus.run}, 32'd0);

        // Reset in the middle of an operation clears everything at once.
        e = model(1'b0, 1'b0, 32'h00005555, 32'd0);
        applyStimulus("pre-reset dbz", 1'b0, 1'b0, 32'h00005555, 32'd0, e);
        launch(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset run", {31'b0, bus.run}, 32'd0);
        checkOutput("midreset prodh", bus.prodh, 32'd0);
        checkOutput("midreset prodl", bus.prodl, 32'd0);
        checkOutput("midreset dividebyzero", {31'b0, bus.dividebyzero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Corner operand sweep for every op type.
        for (int mi = 0; mi < 2; mi++) begin
            for (int si = 0; si < 2; si++) begin
                for (int i = 0; i < 9; i++) begin
                    for (int j = 0; j < 9; j++) begin
                        m = 1'(mi);
                        s = 1'(si);
                        e = model(m, s, corners[i], corners[j]);
                        applyStimulus($sformatf("sweep m%0d s%0d %h,%h", mi, si, corners[i], corners[j]),
                                      m, s, corners[i], corners[j], e);
                    end
                end
            end
        end

        // Random operations, occasional zero divisor.
        for (int k = 0; k < 60; k++) begin
            m  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            e  = model(m, s, rx, ry);
            applyStimulus($sformatf("rand%0d m%0d s%0d %h,%h", k, m, s, rx, ry), m, s, rx, ry, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
